// File: rtl/av2_recon_writeback.sv
// av2_recon_writeback: joins prediction and residual streams, adds and clips, and writes reconstructed pixels in raster order
module av2_recon_writeback #(
  parameter int BIT_DEPTH = 10,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    frame_base,
  input  logic [15:0]          frame_stride,
  input  logic [15:0]          block_x,
  input  logic [15:0]          block_y,
  input  logic [6:0]           block_width,
  input  logic [6:0]           block_height,
  input  logic [BIT_DEPTH-1:0] pred_data,
  input  logic                 pred_valid,
  output logic                 pred_ready,
  input  logic [15:0]          resid_data,
  input  logic                 resid_valid,
  output logic                 resid_ready,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [BIT_DEPTH-1:0] wr_data,
  output logic                 wr_en,
  input  logic                 wr_ready,
  output logic                 busy,
  output logic                 done,
  output logic [14:0]          sat_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [16:0] PMAX = 17'((1 << BIT_DEPTH) - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, wr_addr_q, wr_addr_d, y_a, x_a, addr;
  logic [15:0] stride_q, stride_d, bx_q, bx_d, by_q, by_d;
  logic [6:0] w_q, w_d, h_q, h_d, row_q, row_d, col_q, col_d;
  logic [BIT_DEPTH-1:0] wr_data_q, wr_data_d, pix;
  logic [14:0] sat_q, sat_d;
  logic wr_en_q, wr_en_d, done_q, done_d;
  logic launch, take_ok, consume, col_last, last, neg, over;
  logic [16:0] sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    launch = state_q == IDLE && start;
    take_ok = state_q == RUN && (!wr_en_q || wr_ready);
    consume = take_ok && pred_valid && resid_valid;
    col_last = col_q == w_q - 7'd1;
    last = col_last && row_q == h_q - 7'd1;
    state_d = launch ? RUN :
              (state_q == RUN && consume && last) ? DRAIN :
              (state_q == DRAIN && wr_en_q && wr_ready) ? IDLE : state_q;
  end
  always_comb begin
    pred_ready = take_ok;
    resid_ready = take_ok;
    busy = state_q != IDLE;
  end
  // Two's complement add at 17 bits: sign bit set means the sum went negative
  always_comb begin
    sum = {{(17-BIT_DEPTH){1'b0}}, pred_data} + {resid_data[15], resid_data};
    neg = sum[16];
    over = !neg && sum > PMAX;
    pix = neg ? '0 : over ? PMAX[BIT_DEPTH-1:0] : sum[BIT_DEPTH-1:0];
    y_a = ADDR_W'(by_q) + ADDR_W'(row_q);
    x_a = ADDR_W'(bx_q) + ADDR_W'(col_q);
    addr = base_q + y_a * ADDR_W'(stride_q) + x_a;
    base_d = launch ? frame_base : base_q;
    stride_d = launch ? frame_stride : stride_q;
    bx_d = launch ? block_x : bx_q;
    by_d = launch ? block_y : by_q;
    w_d = launch ? block_width : w_q;
    h_d = launch ? block_height : h_q;
    row_d = launch ? '0 : (consume && col_last) ? row_q + 7'd1 : row_q;
    col_d = launch ? '0 : consume ? (col_last ? '0 : col_q + 7'd1) : col_q;
    wr_en_d = consume || (wr_en_q && !wr_ready);
    wr_addr_d = consume ? addr : wr_addr_q;
    wr_data_d = consume ? pix : wr_data_q;
    sat_d = launch ? '0 : (consume && (neg || over) && sat_q != 15'h7FFF) ? sat_q + 15'd1 : sat_q;
    done_d = state_q == DRAIN && wr_en_q && wr_ready;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      base_q <= '0;
      stride_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      w_q <= '0;
      h_q <= '0;
      row_q <= '0;
      col_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sat_q <= '0;
      done_q <= 1'b0;
    end else begin
      base_q <= base_d;
      stride_q <= stride_d;
      bx_q <= bx_d;
      by_q <= by_d;
      w_q <= w_d;
      h_q <= h_d;
      row_q <= row_d;
      col_q <= col_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sat_q <= sat_d;
      done_q <= done_d;
    end
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en = wr_en_q;
  assign done = done_q;
  assign sat_count = sat_q;
endmodule

// File: doc/av2_recon_writeback.md
# av2_recon_writeback

Reconstruction stage directly downstream of motion compensation. It joins the prediction pixel stream with the residual stream, adds each pair and clips the result to the pixel range. Reconstructed pixels are written in raster order to the reconstructed-frame buffer, one pixel per cycle, with full back-pressure on every interface.

## Interface
- BIT_DEPTH, 10, pixel width; clip range is 0..2^BIT_DEPTH-1
- ADDR_W, 32, frame-buffer address width, in pixel units
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin block; sampled only in IDLE
- frame_base  in  ADDR_W  reconstructed-frame base address
- frame_stride  in  16  row pitch in pixels
- block_x, block_y  in  16 each  block origin in pixels
- block_width, block_height  in  7 each  block size; 0 encodes 128
- pred_data  in  BIT_DEPTH  prediction pixel, unsigned
- pred_valid / pred_ready  in / out  1  prediction stream handshake
- resid_data  in  16  residual, signed two's complement
- resid_valid / resid_ready  in / out  1  residual stream handshake
- wr_addr  out  ADDR_W  write address
- wr_data  out  BIT_DEPTH  reconstructed pixel
- wr_en  out  1  write valid
- wr_ready  in  1  frame buffer accepts write
- busy  out  1  block in progress
- done  out  1  one-cycle pulse, block complete
- sat_count  out  15  clipped pixels in current/last block

## Operation
- All block parameters are latched on start in IDLE. start in any other state is ignored.
- States:
  - IDLE: start → RUN. Latch the parameters, clear the row/column counters, clear sat_count.
  - RUN: consume pixels. When the last pixel is consumed → DRAIN.
  - DRAIN: wait for the final write to be accepted, then → IDLE with a done pulse.
- Join rule: a pixel is consumed on a cycle when all of the following hold:
  - state is RUN
  - pred_valid and resid_valid are both high
  - the output slot is free, meaning !wr_en or wr_ready
- pred_ready and resid_ready are both equal to that condition excluding the valids. Both streams are always consumed together.
- Arithmetic:
  - sum = {0, pred_data} + sign-extended resid_data, computed in 17-bit signed.
  - If sum < 0, output 0. If sum > 2^BIT_DEPTH-1, output the max. Otherwise output sum.
  - Either clip increments sat_count. sat_count saturates at 0x7FFF.
- Address = frame_base + (block_y + row) * frame_stride + block_x + col. Computed at ADDR_W bits and wraps modulo 2^ADDR_W.
- Counters:
  - col runs 0..W-1. At W-1 it wraps to 0 and row increments.
  - The last pixel is row = H-1, col = W-1.
  - W or H = 0 means 128, so the maximum is 16384 pixels.
- Output register: wr_addr, wr_data and wr_en load on consume. While wr_en=1 and wr_ready=0, all three hold stable. wr_en drops after acceptance when no new pixel is consumed.

## Timing
- Reset values:
  - state IDLE
  - wr_en=0, wr_addr=0, wr_data=0
  - pred_ready=0, resid_ready=0
  - busy=0, done=0, sat_count=0
- Reset mid-block abandons the block immediately. No done pulse is produced.
- start at cycle N gives busy=1 from N+1. The earliest consume is cycle N+1. The earliest wr_en is N+2.
- Pixel latency from consume to wr_en is 1 cycle. Throughput is 1 pixel/cycle with continuous valids and wr_ready=1.
- If the last write is accepted at cycle M:
  - done=1 at cycle M+1 for exactly one cycle.
  - busy=0 from M+1.
  - A new start is accepted at M+1.
- A consume and a write acceptance in the same cycle is legal and sustains full rate.
- sat_count updates in the same cycle the clipped pixel loads into the output register.

## Test plan
- 4x4 block, base 0x1000, stride 64, origin (8,2), pred=128, resid=+10 on all pixels → 16 writes of 138.
  - First write address is 0x1000+2*64+8 = 0x1088.
  - Row 1 starts at 0x10C8.
  - done pulses once and sat_count=0.
- Clipping: pred=1000/resid=+100 → 1023; pred=5/resid=-20 → 0; pred=0/resid=+1023 → 1023 (not counted). Final sat_count=2.
- Back-pressure: hold wr_ready=0 for 5 cycles mid-block → wr_addr/wr_data/wr_en stable and both readys low. Release → no pixel lost or duplicated.
- Stream skew: pred_valid toggles every cycle while resid_valid is constant → consumes occur only when both are high, and the output sequence matches a reference model.
- block_width=0, block_height=1 → 128 writes, then done. start pulsed mid-block is ignored.
- rst asserted after 7 of 16 pixels → all outputs return to reset values asynchronously and no done pulse. A subsequent start processes a fresh block correctly.
